// File: rtl/cmp_result_collector.sv
// cmp_result_collector: buffers tagged compare results in a show-ahead FIFO
// and keeps sticky condition flags plus a saturating overflow drop count.
module cmp_result_collector #(
  parameter int Data_Depth = 4,
  parameter int Tag_Width  = 4,
  parameter int Cnt_Width  = 8
) (
  input  logic                        CLK_in,
  input  logic                        RST_in,
  input  logic [1:0]                  cmp_out_in,
  input  logic                        cmp_flag_in,
  input  logic                        clear_in,
  input  logic                        rd_ready_in,
  output logic                        res_valid,
  output logic [1:0]                  res_code,
  output logic                        res_eq,
  output logic                        res_gt,
  output logic                        res_lt,
  output logic [Tag_Width-1:0]        res_tag,
  output logic                        sticky_eq,
  output logic                        sticky_gt,
  output logic                        sticky_lt,
  output logic                        fifo_full,
  output logic [$clog2(Data_Depth):0] fifo_count,
  output logic [Cnt_Width-1:0]        drop_cnt
);
  localparam int AW = $clog2(Data_Depth);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(Data_Depth);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [Tag_Width-1:0] TAG_ONE = Tag_Width'(1);
  localparam logic [Cnt_Width-1:0] DROP_ONE = Cnt_Width'(1);
  localparam logic [Cnt_Width-1:0] DROP_MAX = '1;

  logic [1:0]           code_mem_q [Data_Depth];
  logic [1:0]           code_mem_d [Data_Depth];
  logic [Tag_Width-1:0] tag_mem_q  [Data_Depth];
  logic [Tag_Width-1:0] tag_mem_d  [Data_Depth];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [Tag_Width-1:0] tag_q, tag_d;
  logic [2:0]           sticky_q, sticky_d;
  logic [Cnt_Width-1:0] drop_q, drop_d;

  logic                 pop, push, drop_ev;
  logic [Tag_Width-1:0] tag_base;
  logic [Cnt_Width-1:0] drop_base;

  assign res_valid  = count_q != '0;
  assign fifo_full  = count_q == CNT_FULL;
  assign fifo_count = count_q;
  assign drop_cnt   = drop_q;
  assign sticky_eq  = sticky_q[0];
  assign sticky_gt  = sticky_q[1];
  assign sticky_lt  = sticky_q[2];
  assign res_code   = res_valid ? code_mem_q[rd_ptr_q] : 2'b00;
  assign res_tag    = res_valid ? tag_mem_q[rd_ptr_q] : '0;
  assign res_eq     = res_code == 2'd1;
  assign res_gt     = res_code == 2'd2;
  assign res_lt     = res_code == 2'd3;

  always_comb begin
    pop       = res_valid && rd_ready_in;
    push      = cmp_flag_in && (!fifo_full || pop);
    drop_ev   = cmp_flag_in && fifo_full && !pop;
    // a same-edge clear restarts from zero before the event applies
    tag_base  = clear_in ? '0 : tag_q;
    drop_base = clear_in ? '0 : drop_q;
    code_mem_d = code_mem_q;
    tag_mem_d  = tag_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tag_d      = tag_base;
    drop_d     = drop_base;
    sticky_d   = clear_in ? 3'b000 : sticky_q;
    if (cmp_flag_in) begin
      tag_d    = tag_base + TAG_ONE;
      sticky_d = sticky_d | {cmp_out_in == 2'd3,
                             cmp_out_in == 2'd2,
                             cmp_out_in == 2'd1};
    end
    if (drop_ev && drop_base != DROP_MAX) drop_d = drop_base + DROP_ONE;
    if (push) begin
      code_mem_d[wr_ptr_q] = cmp_out_in;
      tag_mem_d[wr_ptr_q]  = tag_base;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge CLK_in or negedge RST_in) begin
    if (!RST_in) begin
      code_mem_q <= '{default: '0};
      tag_mem_q  <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tag_q      <= '0;
      sticky_q   <= '0;
      drop_q     <= '0;
    end else begin
      code_mem_q <= code_mem_d;
      tag_mem_q  <= tag_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tag_q      <= tag_d;
      sticky_q   <= sticky_d;
      drop_q     <= drop_d;
    end
  end
endmodule

// File: tb/tb_cmp_result_collector.sv
// tb_cmp_result_collector: scoreboard bench for the compare result collector.
// Expected entries are queued on stimulus and compared when popped.
module tb_cmp_result_collector;
  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cmp_out_in = '0;
  logic          cmp_flag_in = 1'b0;
  logic          clear_in = 1'b0;
  logic          rd_ready_in = 1'b0;
  logic          res_valid;
  logic [1:0]    res_code;
  logic          res_eq, res_gt, res_lt;
  logic [TW-1:0] res_tag;
  logic          sticky_eq, sticky_gt, sticky_lt;
  logic          fifo_full;
  logic [2:0]    fifo_count;
  logic [CW-1:0] drop_cnt;

  cmp_result_collector #(
    .Data_Depth(DEPTH), .Tag_Width(TW), .Cnt_Width(CW)
  ) dut (
    .CLK_in(clk), .RST_in(rst_n),
    .cmp_out_in(cmp_out_in), .cmp_flag_in(cmp_flag_in),
    .clear_in(clear_in), .rd_ready_in(rd_ready_in),
    .res_valid(res_valid), .res_code(res_code),
    .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt),
    .res_tag(res_tag),
    .sticky_eq(sticky_eq), .sticky_gt(sticky_gt), .sticky_lt(sticky_lt),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [1:0]    code;
  } ent_t;

  ent_t          exp_q[$];
  logic [TW-1:0] m_tag = '0;
  logic [2:0]    m_sticky = '0;
  logic [CW-1:0] m_drop = '0;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] dec(input logic [1:0] c);
    case (c)
      2'd1:    dec = 3'b100;
      2'd2:    dec = 3'b010;
      2'd3:    dec = 3'b001;
      default: dec = 3'b000;
    endcase
  endfunction

  task automatic check_state(input string w);
    check({w, ".valid"}, 32'(res_valid), 32'(exp_q.size() != 0));
    check({w, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
    check({w, ".full"}, 32'(fifo_full), 32'(exp_q.size() == DEPTH));
    check({w, ".sticky"}, 32'({sticky_lt, sticky_gt, sticky_eq}),
          32'(m_sticky));
    check({w, ".drop"}, 32'(drop_cnt), 32'(m_drop));
    if (exp_q.size() != 0) begin
      check({w, ".htag"}, 32'(res_tag), 32'(exp_q[0].tag));
      check({w, ".hcode"}, 32'(res_code), 32'(exp_q[0].code));
    end else begin
      check({w, ".ecode"}, 32'({res_code, res_eq, res_gt, res_lt}), 32'(0));
      check({w, ".etag"}, 32'(res_tag), 32'(0));
    end
  endtask

  task automatic cyc(input logic f, input logic [1:0] c,
                     input logic r, input logic clr);
    logic [TW-1:0] t0;
    bit            was_full, pop;
    ent_t          h;
    cmp_flag_in = f;
    cmp_out_in  = c;
    rd_ready_in = r;
    clear_in    = clr;
    was_full = exp_q.size() == DEPTH;
    pop      = r && exp_q.size() != 0;
    if (pop) begin
      h = exp_q.pop_front();
      check("pop.tag", 32'(res_tag), 32'(h.tag));
      check("pop.code", 32'(res_code), 32'(h.code));
      check("pop.dec", 32'({res_eq, res_gt, res_lt}), 32'(dec(h.code)));
    end
    t0 = clr ? '0 : m_tag;
    if (clr) begin
      m_sticky = '0;
      m_drop   = '0;
    end
    m_tag = t0;
    if (f) begin
      m_tag = t0 + 1'b1;
      if (c != 2'd0) m_sticky[c - 2'd1] = 1'b1;
      if (!was_full || pop) exp_q.push_back(ent_t'{tag: t0, code: c});
      else if (m_drop != '1) m_drop = m_drop + 1'b1;
    end
    @(posedge clk);
    #1;
    cmp_flag_in = 1'b0;
    rd_ready_in = 1'b0;
    clear_in    = 1'b0;
    check_state("cyc");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst.async_valid", 32'(res_valid), 32'(0));
    check("rst.async_count", 32'(fifo_count), 32'(0));
    exp_q.delete();
    m_tag    = '0;
    m_sticky = '0;
    m_drop   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state("rst");
  endtask

  initial begin
    @(posedge clk);
    #1;
    check_state("init");
    rst_n = 1'b1;

    // reset in the middle of a stream
    cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd2, 0, 0);
    cyc(1, 2'd3, 0, 0);
    do_reset();
    check("rst.sticky0", 32'({sticky_lt, sticky_gt, sticky_eq}), 32'(0));
    cyc(1, 2'd2, 0, 0);
    check("rst.tag0", 32'(res_tag), 32'(0));
    cyc(0, 2'd0, 1, 0);

    // ordering and decode
    for (int i = 0; i < 4; i++) cyc(1, 2'(i), 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 1, 0);
    check("ord.sticky", 32'({sticky_lt, sticky_gt, sticky_eq}), 32'(7));

    // overflow, then full push/pop
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 2'(i % 4), 0, 0);
    check("ovf.drop", 32'(drop_cnt), 32'(2));
    check("ovf.full", 32'(fifo_full), 32'(1));
    cyc(1, 2'd1, 1, 0);
    check("pp.count", 32'(fifo_count), 32'(4));
    check("pp.drop", 32'(drop_cnt), 32'(2));

    // saturation and clear race
    for (int i = 0; i < 3; i++) cyc(1, 2'd3, 0, 0);
    check("sat.drop", 32'(drop_cnt), 32'(3));
    cyc(1, 2'd1, 0, 0);
    check("sat.hold", 32'(drop_cnt), 32'(3));
    cyc(1, 2'd2, 0, 1);
    check("clr.sticky", 32'({sticky_lt, sticky_gt, sticky_eq}), 32'(2));
    check("clr.drop", 32'(drop_cnt), 32'(1));
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 1, 0);
    cyc(1, 2'd0, 0, 0);
    check("clr.nexttag", 32'(res_tag), 32'(1));
    cyc(0, 2'd0, 1, 0);

    // tag wrap while streaming
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, 2'($urandom % 4), 1, 0);
    check("wrap.tag", 32'(res_tag), 32'(0));
    check("wrap.drop", 32'(drop_cnt), 32'(0));
    cyc(0, 2'd0, 1, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
          1'(($urandom % 16) == 0));

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cyc(0, 2'd0, 1, 0);
    check("end.empty", 32'(fifo_count), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmp_result_collector.md
Name: cmp_result_collector

Overview:
- Consumer end of the compare unit's registered result interface (`cmp_out` / `cmp_flag`).
- Samples each flagged compare result and decodes the 2-bit code into EQ/GT/LT/false.
- Tags each result with a sequence number and buffers it in a small FIFO, drained by a downstream reader over a valid/ready handshake.
- Also keeps sticky condition flags and a saturating count of results dropped on overflow.

Parameters:
- Data_Depth, 4, FIFO entries; power of 2, minimum 2.
- Tag_Width, 4, width of the sequence tag; wraps modulo 2^Tag_Width.
- Cnt_Width, 8, width of the saturating drop counter.

Ports:
- CLK_in  input  1  clock, rising edge.
- RST_in  input  1  asynchronous, active-low reset.
- cmp_out_in  input  2  compare result code from the compare unit's registered output.
- cmp_flag_in  input  1  qualifies cmp_out_in; 1 = a compare result is present this cycle.
- clear_in  input  1  synchronous clear of sticky flags, drop counter and tag counter.
- rd_ready_in  input  1  downstream accepts the head entry this cycle.
- res_valid  output  1  FIFO not empty; head entry presented.
- res_code  output  2  raw code of head entry.
- res_eq / res_gt / res_lt  output  1 each  decoded head: code 1 / 2 / 3; all 0 for code 0 (condition false).
- res_tag  output  Tag_Width  sequence tag of head entry.
- sticky_eq / sticky_gt / sticky_lt  output  1 each  set once any flagged result had code 1 / 2 / 3.
- fifo_full  output  1  occupancy == Data_Depth.
- fifo_count  output  log2(Data_Depth)+1  current occupancy.
- drop_cnt  output  Cnt_Width  saturating count of results lost on overflow.

Behaviour:
- Clock and reset: one clock (CLK_in) with asynchronous active-low reset (RST_in). On reset assertion:
  - pointers = 0, fifo_count = 0
  - res_valid = 0, fifo_full = 0
  - tag counter = 0
  - all sticky flags = 0, drop_cnt = 0
  - res_code / res_eq / res_gt / res_lt / res_tag read as 0 while empty.
- Reset mid-operation discards all stored entries; no partial state survives.
- Event: a rising edge with cmp_flag_in = 1. cmp_out_in is ignored when cmp_flag_in = 0. At most one event per cycle.
- Entry: {tag counter, cmp_out_in}. The tag counter increments on every event, accepted or dropped, so drops show as tag gaps. Wraps from 2^Tag_Width-1 to 0.
- Push: event and (not full, or pop in the same cycle). The entry is written at the write pointer.
- Latency: an event at edge k makes res_valid = 1 after edge k if the FIFO was empty.
- Pop: res_valid = 1 and rd_ready_in = 1 at the edge; the read pointer advances. rd_ready_in while empty has no effect.
- Head presentation: show-ahead. res_* are driven from the entry at the read pointer and stay stable until popped; decode is combinational from the stored code.
- Simultaneous push and pop:
  - fifo_count unchanged.
  - When full, both succeed; no drop.
  - When count = 1, the new entry becomes the head on the next cycle.
- Overflow: an event while full with no pop.
  - Entry discarded; FIFO contents unchanged.
  - drop_cnt increments, saturating at all-ones.
  - Tag still increments.
- Pointers: wrap modulo Data_Depth. Full/empty are derived from fifo_count.
- Sticky flags: set on any event (including dropped ones) by code 1/2/3. Code 0 sets none.
- clear_in:
  - Zeroes sticky flags, drop_cnt and tag counter at the edge. The FIFO is not flushed.
  - If an event occurs on the same edge, the event's sticky set wins over the clear.
  - The event's entry uses tag 0 and the tag counter becomes 1.
  - A same-edge drop leaves drop_cnt = 1.
- No combinational path from cmp_flag_in / cmp_out_in to any output; all state is registered.

Test Plan:
- Reset mid-stream: 3 events (codes 1,2,3), then RST_in low for 1 cycle -> res_valid = 0, fifo_count = 0, sticky_* = 0, drop_cnt = 0; next event gets tag 0.
- Ordering/decode: with rd_ready_in = 0, events with codes 0,1,2,3, then rd_ready_in = 1 -> pops tags 0..3 in order.
  - Code 0 pops with res_eq/gt/lt = 000.
  - Code 1 pops as 100, code 2 as 010, code 3 as 001.
  - sticky_eq = sticky_gt = sticky_lt = 1.
- Overflow: Data_Depth = 4, 6 events with rd_ready_in = 0 -> fifo_full = 1, drop_cnt = 2, stored tags 0..3; the next event is tag 6.
- Full with simultaneous push/pop: FIFO full, event and rd_ready_in = 1 on the same edge -> no drop, fifo_count stays 4, new entry at the tail.
- Saturation and clear race: Cnt_Width = 2, 5 drops -> drop_cnt = 3 (held). Then clear_in with a code-2 event on the same edge while full -> sticky_gt = 1, others 0, drop_cnt = 1.
- Tag wrap: Tag_Width = 4, 17 events streamed with rd_ready_in = 1 -> the 17th entry pops with res_tag = 0; no drops.
